vga_bars_ctrl: RTL and testbench

VGA_BARS_CTRL -- requirements
Module: vga_bars_ctrl

---
 rtl/vga_bars_ctrl.sv | 177 +++++++++++++++++
 tb/tb_vga_bars_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_bars_ctrl.sv
// ---------------------------------------------------------------------------
// vga_bars_ctrl
//   Animation controller for the VgaBars pattern. It turns the VGA vertical
//   sync into a one-cycle frame tick and moves a horizontal split line up and
//   down between row 0 and row MAX_Y. A single toggle pulse starts the
//   animation, pauses it, and resumes it in the direction it was moving.
//
// Parameters
//   MAX_Y      lowest row the split line reaches (1..511)
//   STEP       rows moved per step event (1..8)
//   FRAME_DIV  frame ticks per step event (1..255)
//
// Ports
//   i_Clk           sole clock, rising edge
//   i_Reset         synchronous, active-high reset
//   i_VSync         active-low vertical sync from the timing generator
//   i_Toggle        one-cycle pulse: start / pause / resume
//   i_SpeedUp       (VGA_BARS_CTRL_SPEED_EN only) one-cycle pulse, step + 1
//   i_SpeedDown     (VGA_BARS_CTRL_SPEED_EN only) one-cycle pulse, step - 1
//   o_NewFrameTick  one-cycle pulse per frame (VgaBars frame-tick input)
//   o_SplitLineY    current split-line row, 0..MAX_Y
//   o_Direction     0 = moving down (Y increasing), 1 = moving up
//   o_Running       high while animating (RUN_DOWN / RUN_UP)
//
// Configuration
//   `define VGA_BARS_CTRL_SPEED_EN to add the run-time speed controls; the
//   default build uses the constant STEP.
// ---------------------------------------------------------------------------
module vga_bars_ctrl #(
    parameter int MAX_Y     = 479,
    parameter int STEP      = 1,
    parameter int FRAME_DIV = 1
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_VSync,
    input  logic       i_Toggle,
`ifdef VGA_BARS_CTRL_SPEED_EN
    input  logic       i_SpeedUp,
    input  logic       i_SpeedDown,
`endif
    output logic       o_NewFrameTick,
    output logic [8:0] o_SplitLineY,
    output logic       o_Direction,
    output logic       o_Running
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN_DOWN = 2'd1;
    localparam logic [1:0] ST_RUN_UP   = 2'd2;
    localparam logic [1:0] ST_PAUSED   = 2'd3;

    localparam logic [9:0] MAX_Y_W   = 10'(MAX_Y);
    localparam logic [8:0] MAX_Y_ROW = 9'(MAX_Y);
    localparam logic [7:0] DIV_LAST  = 8'(FRAME_DIV - 1);
    localparam logic [3:0] STEP_INIT = 4'(STEP);

    logic [1:0] state, state_n;
    logic [8:0] y, y_n;
    logic       dir, dir_n;
    logic [7:0] div_cnt, div_cnt_n;
    logic [3:0] step;
    logic       r_VSync;
    logic       running;
    logic [9:0] y_sum;
    logic [9:0] y_w;
    logic [9:0] step_w;

    assign running = (state == ST_RUN_DOWN) || (state == ST_RUN_UP);

    // ---------------------------------------------------------------------
    // Step size: constant, or a saturating 1..8 register when speed control
    // is built in. Opposing pulses in the same cycle cancel.
    // ---------------------------------------------------------------------
`ifdef VGA_BARS_CTRL_SPEED_EN
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            step <= STEP_INIT;
        end else if (i_SpeedUp && !i_SpeedDown && step != 4'd8) begin
            step <= step + 4'd1;
        end else if (i_SpeedDown && !i_SpeedUp && step != 4'd1) begin
            step <= step - 4'd1;
        end
    end
`else
    assign step = STEP_INIT;
`endif

    // Ten-bit intermediates keep Y + step from wrapping past row 511.
    assign y_w    = {1'b0, y};
    assign step_w = {6'd0, step};
    assign y_sum  = y_w + step_w;

    // ---------------------------------------------------------------------
    // Next-state logic. A toggle always wins over a coincident step event,
    // so the split line never moves in a cycle that changes run/pause state.
    // The step event is the registered frame tick seen while running.
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_n   = state;
        y_n       = y;
        dir_n     = dir;
        div_cnt_n = div_cnt;

        if (i_Toggle) begin
            case (state)
                ST_IDLE: begin
                    state_n   = ST_RUN_DOWN;
                    dir_n     = 1'b0;
                    div_cnt_n = 8'd0;
                end
                ST_RUN_DOWN, ST_RUN_UP: begin
                    // dir keeps the direction for the later resume
                    state_n = ST_PAUSED;
                end
                default: begin
                    state_n   = dir ? ST_RUN_UP : ST_RUN_DOWN;
                    div_cnt_n = 8'd0;
                end
            endcase
        end else if (running && o_NewFrameTick) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt_n = 8'd0;
                if (state == ST_RUN_DOWN) begin
                    if (y_sum >= MAX_Y_W) begin
                        y_n     = MAX_Y_ROW;
                        state_n = ST_RUN_UP;
                        dir_n   = 1'b1;
                    end else begin
                        y_n = y_sum[8:0];
                    end
                end else begin
                    if (y_w <= step_w) begin
                        y_n     = 9'd0;
                        state_n = ST_RUN_DOWN;
                        dir_n   = 1'b0;
                    end else begin
                        y_n = y - {5'd0, step};
                    end
                end
            end else begin
                div_cnt_n = div_cnt + 8'd1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // State registers and frame-tick detection. r_VSync clears on reset so a
    // sync that is already low at reset does not produce a spurious tick.
    // ---------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (i_Reset) begin
            state          <= ST_IDLE;
            y              <= 9'd0;
            dir            <= 1'b0;
            div_cnt        <= 8'd0;
            r_VSync        <= 1'b0;
            o_NewFrameTick <= 1'b0;
        end else begin
            state          <= state_n;
            y              <= y_n;
            dir            <= dir_n;
            div_cnt        <= div_cnt_n;
            r_VSync        <= i_VSync;
            o_NewFrameTick <= r_VSync && !i_VSync;
        end
    end

    assign o_SplitLineY = y;
    assign o_Direction  = dir;
    assign o_Running    = running;

endmodule

// File: tb/tb_vga_bars_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_bars_ctrl
//   Self-checking bench for vga_bars_ctrl. Three instances share clock,
//   reset and sync but have their own toggle:
//     [0] defaults, [1] MAX_Y=10 STEP=4, [2] FRAME_DIV=3.
//   A frame-level reference model tracks the expected split line of each
//   instance; directed steps and a random phase are compared against it and
//   against hand-derived constants.
//   With VGA_BARS_CTRL_SPEED_EN defined the speed ports are also driven.
// ---------------------------------------------------------------------------
module tb_vga_bars_ctrl;

    localparam int N = 3;
    localparam int P_MAX[N]  = '{479, 10, 479};
    localparam int P_STEP[N] = '{1, 4, 1};
    localparam int P_DIV[N]  = '{1, 1, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync = 1'b0;
    logic       tog[N];
    logic       tick[N];
    logic [8:0] y_o[N];
    logic       dir_o[N];
    logic       run_o[N];
`ifdef VGA_BARS_CTRL_SPEED_EN
    logic       spd_up = 1'b0;
    logic       spd_dn = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: frame-level view of each instance
    int m_y[N];
    int m_cnt[N];
    int m_step[N];
    bit m_run[N];
    bit m_pause[N];
    bit m_dir[N];

    always #5 clk = ~clk;

    vga_bars_ctrl #(.MAX_Y(P_MAX[0]), .STEP(P_STEP[0]), .FRAME_DIV(P_DIV[0])) u_def (
        .i_Clk(clk), .i_Reset(rst), .i_VSync(vsync), .i_Toggle(tog[0]),
`ifdef VGA_BARS_CTRL_SPEED_EN
        .i_SpeedUp(spd_up), .i_SpeedDown(spd_dn),
`endif
        .o_NewFrameTick(tick[0]), .o_SplitLineY(y_o[0]),
        .o_Direction(dir_o[0]), .o_Running(run_o[0])
    );

    vga_bars_ctrl #(.MAX_Y(P_MAX[1]), .STEP(P_STEP[1]), .FRAME_DIV(P_DIV[1])) u_small (
        .i_Clk(clk), .i_Reset(rst), .i_VSync(vsync), .i_Toggle(tog[1]),
`ifdef VGA_BARS_CTRL_SPEED_EN
        .i_SpeedUp(spd_up), .i_SpeedDown(spd_dn),
`endif
        .o_NewFrameTick(tick[1]), .o_SplitLineY(y_o[1]),
        .o_Direction(dir_o[1]), .o_Running(run_o[1])
    );

    vga_bars_ctrl #(.MAX_Y(P_MAX[2]), .STEP(P_STEP[2]), .FRAME_DIV(P_DIV[2])) u_div (
        .i_Clk(clk), .i_Reset(rst), .i_VSync(vsync), .i_Toggle(tog[2]),
`ifdef VGA_BARS_CTRL_SPEED_EN
        .i_SpeedUp(spd_up), .i_SpeedDown(spd_dn),
`endif
        .o_NewFrameTick(tick[2]), .o_SplitLineY(y_o[2]),
        .o_Direction(dir_o[2]), .o_Running(run_o[2])
    );

    // ------------------------------------------------------------------ model
    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_y[i] = 0; m_cnt[i] = 0; m_step[i] = P_STEP[i];
            m_run[i] = 0; m_pause[i] = 0; m_dir[i] = 0;
        end
    endfunction

    function automatic void model_toggle(input int i);
        if (m_run[i]) begin
            m_run[i] = 0; m_pause[i] = 1;
        end else begin
            if (!m_pause[i]) m_dir[i] = 0;
            m_run[i] = 1; m_pause[i] = 0; m_cnt[i] = 0;
        end
    endfunction

    // one frame tick: every FRAME_DIV-th tick bounces the line by step rows
    function automatic void model_tick(input int i);
        if (!m_run[i]) return;
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] < P_DIV[i]) return;
        m_cnt[i] = 0;
        if (!m_dir[i]) begin
            m_y[i] = m_y[i] + m_step[i];
            if (m_y[i] >= P_MAX[i]) begin m_y[i] = P_MAX[i]; m_dir[i] = 1; end
        end else begin
            m_y[i] = m_y[i] - m_step[i];
            if (m_y[i] <= 0) begin m_y[i] = 0; m_dir[i] = 0; end
        end
    endfunction

    function automatic void model_speed(input bit up, input bit dn);
        for (int i = 0; i < N; i++) begin
            if (up && !dn) m_step[i] = (m_step[i] < 8) ? m_step[i] + 1 : 8;
            if (dn && !up) m_step[i] = (m_step[i] > 1) ? m_step[i] - 1 : 1;
        end
    endfunction

    // --------------------------------------------------------------- checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_y%0d", tag, i),   32'(y_o[i]),   32'(m_y[i]));
            check($sformatf("%s_dir%0d", tag, i), 32'(dir_o[i]), 32'(m_dir[i]));
            check($sformatf("%s_run%0d", tag, i), 32'(run_o[i]), 32'(m_run[i]));
        end
    endtask

    // --------------------------------------------------------------- stimulus
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_all("reset");
        for (int i = 0; i < N; i++) check($sformatf("reset_tick%0d", i), 32'(tick[i]), 0);
    endtask

    task automatic do_toggle(input int i);
        tog[i] = 1'b1;
        @(posedge clk); #1;
        tog[i] = 1'b0;
        model_toggle(i);
        check_all("toggle");
    endtask

    // One VSync frame: high for hi cycles, then low. Instances in tmask get
    // their toggle during the tick cycle, so the toggle meets the step event.
    task automatic do_frame(input int hi, input int lo, input bit [N-1:0] tmask);
        int extra;
        vsync = 1'b1;
        repeat (hi) begin @(posedge clk); #1; end
        vsync = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("tick_rise%0d", i), 32'(tick[i]), 1);
            if (tmask[i]) tog[i] = 1'b1;
        end
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) tog[i] = 1'b0;
        extra = 0;
        for (int i = 0; i < N; i++) extra += int'(tick[i]);
        repeat (lo) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) extra += int'(tick[i]);
        end
        check("tick_single", 32'(extra), 0);
        for (int i = 0; i < N; i++) begin
            if (tmask[i]) model_toggle(i);
            else model_tick(i);
        end
        check_all("frame");
    endtask

`ifdef VGA_BARS_CTRL_SPEED_EN
    task automatic do_speed(input bit up, input bit dn);
        spd_up = up; spd_dn = dn;
        @(posedge clk); #1;
        spd_up = 1'b0; spd_dn = 1'b0;
        model_speed(up, dn);
    endtask
`endif

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached, observed no end expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_y[7];
        int exp_d[7];
        int quiet;
        exp_y = '{4, 8, 10, 6, 2, 0, 4};
        exp_d = '{0, 0, 1, 1, 1, 0, 0};
        for (int i = 0; i < N; i++) tog[i] = 1'b0;

        // reset state, start all instances
        do_reset();
        for (int i = 0; i < N; i++) do_toggle(i);

        // bouncing sequence, tick per frame, divider by 3
        for (int k = 0; k < 9; k++) begin
            do_frame(2, 2, '0);
            if (k < 7) begin
                check("small_seq_y", 32'(y_o[1]), 32'(exp_y[k]));
                check("small_seq_dir", 32'(dir_o[1]), 32'(exp_d[k]));
            end
            if (k == 4) begin
                check("def_y5", 32'(y_o[0]), 5);
                check("def_dir5", 32'(dir_o[0]), 0);
                check("def_run5", 32'(run_o[0]), 1);
            end
        end
        check("div_y3", 32'(y_o[2]), 3);

        // pause / resume on defaults; toggle coincident with step on divider
        do_reset();
        do_toggle(0);
        do_toggle(2);
        do_frame(1, 1, '0);
        do_frame(1, 1, '0);
        do_frame(1, 1, 3'b100);
        check("div_coinc_y", 32'(y_o[2]), 0);
        check("div_coinc_run", 32'(run_o[2]), 0);
        check("def_pause_at", 32'(y_o[0]), 3);
        do_toggle(0);
        repeat (4) do_frame(1, 2, '0);
        check("def_paused_y", 32'(y_o[0]), 3);
        check("def_paused_run", 32'(run_o[0]), 0);
        do_toggle(0);
        do_frame(1, 1, '0);
        check("def_resume_y", 32'(y_o[0]), 4);

        // reset while moving up with VSync held low
        do_reset();
        do_toggle(1);
        repeat (4) do_frame(1, 1, '0);
        check("small_up_dir", 32'(dir_o[1]), 1);
        do_reset();
        check("rst_up_y", 32'(y_o[1]), 0);
        check("rst_up_dir", 32'(dir_o[1]), 0);
        quiet = 0;
        repeat (5) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) quiet += int'(tick[i]);
        end
        check("rst_no_tick", 32'(quiet), 0);
        do_frame(1, 1, '0);

`ifdef VGA_BARS_CTRL_SPEED_EN
        // run-time speed changes observed through the line movement
        do_reset();
        do_toggle(0);
        repeat (3) do_speed(1'b1, 1'b0);
        do_frame(1, 1, '0);
        check("spd_step4", 32'(y_o[0]), 4);
        repeat (10) do_speed(1'b1, 1'b0);
        do_speed(1'b1, 1'b1);
        do_frame(1, 1, '0);
        check("spd_step8", 32'(y_o[0]), 12);
        repeat (9) do_speed(1'b0, 1'b1);
        do_frame(1, 1, '0);
        check("spd_step1", 32'(y_o[0]), 13);
`endif

        // random frames and toggles against the model
        do_reset();
        for (int i = 0; i < N; i++) do_toggle(i);
        for (int k = 0; k < 150; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 7) begin
                do_frame(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
                         (r == 6) ? 3'($urandom_range(0, 7)) : 3'b000);
            end else begin
                do_toggle(int'($urandom_range(0, N - 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
